// File: rtl/snn_image_sequencer.sv
// snn_image_sequencer
// Top-level controller for the SNN inference path. Accepts a packed
// binary image as N_BYTES UART bytes, unpacks it LSB-first into the 1-bit
// input-unit RAM, starts the SNN core, hands it the RAM address port while
// it computes, then returns the classified digit over UART TX and re-arms.
//
// Optional feature macro: SNN_WDOG_EN
//   When defined, COMPUTE is bounded by WDOG_CYCLES cycles. On expiry
//   8'hFF is sent in place of a digit. core_done in the expiry cycle wins.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_LOAD    | idle / waiting for next image byte on rx_rdy
// S_UNPACK  | writing the 8 bits of the latched byte, one per cycle
// S_START   | one-cycle core_start pulse
// S_COMPUTE | core owns the RAM address, waiting for core_done
// S_TX      | one-cycle tx_start pulse with the result byte
// S_TX_WAIT | waiting for tx_done, then clear counters and re-arm

module snn_image_sequencer #(
    parameter int N_BYTES     = 98,
    parameter int ADDR_W      = 10,
    parameter int WDOG_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    output logic              ram_we,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy
);

    localparam int BYTE_CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(N_BYTES - 1);

    // Parameter sanity: the frame must fit in the RAM address space.
    if (N_BYTES < 1 || N_BYTES * 8 > (1 << ADDR_W)) begin : g_bad_frame
        $error("N_BYTES*8 must be between 8 and 2**ADDR_W");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be positive");
    end

    typedef enum logic [2:0] {
        S_LOAD,
        S_UNPACK,
        S_START,
        S_COMPUTE,
        S_TX,
        S_TX_WAIT
    } state_t;

    state_t                state;
    logic [7:0]            shift_reg;
    logic [2:0]            bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [ADDR_W-1:0]     wr_addr;

`ifdef SNN_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;
`endif

    // The ack is combinational so it lands in the same cycle the byte is
    // latched; the UART may still hold rx_rdy during the following cycle,
    // which UNPACK ignores.
    assign clr_rx_rdy = (state == S_LOAD) && rx_rdy;

    // RAM address ownership: core while computing, sequencer otherwise.
    assign ram_addr = (state == S_COMPUTE) ? core_addr : wr_addr;

    // Pixel bit is the bottom of the shift register; it drains to zero
    // after each byte so ram_d rests low outside UNPACK.
    assign ram_d = shift_reg[0];

    // Sequencer FSM with registered strobes, address and result byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            wr_addr    <= '0;
            ram_we     <= 1'b0;
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
`ifdef SNN_WDOG_EN
            wdog_cnt   <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (rx_rdy) begin
                        shift_reg <= rx_data;
                        bit_cnt   <= 3'd0;
                        ram_we    <= 1'b1;
                        state     <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ram_we <= 1'b0;
                        if (byte_cnt == LAST_BYTE) begin
                            // wr_addr parks on the last pixel address
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_START;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            wr_addr  <= wr_addr + 1'b1;
                            state    <= S_LOAD;
                        end
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                S_START: begin
`ifdef SNN_WDOG_EN
                    wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
`endif
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (core_done) begin
                        tx_data  <= {4'h0, core_digit};
                        tx_start <= 1'b1;
                        state    <= S_TX;
                    end
`ifdef SNN_WDOG_EN
                    else if (wdog_cnt == '0) begin
                        tx_data  <= 8'hFF;
                        tx_start <= 1'b1;
                        state    <= S_TX;
                    end else begin
                        wdog_cnt <= wdog_cnt - 1'b1;
                    end
`endif
                end
                S_TX: begin
                    state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_done) begin
                        byte_cnt <= '0;
                        wr_addr  <= '0;
                        busy     <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_image_sequencer.sv
// Testbench for snn_image_sequencer: random images are streamed over the
// RX handshake, the written RAM contents are captured into a bench-side
// memory and compared with the image, and handshake / result timing is
// predicted from the frame rules. Watchdog scenarios run when
// SNN_WDOG_EN is defined.

module tb_snn_image_sequencer;

    localparam int NB   = 98;
    localparam int AW   = 10;
    localparam int NPIX = NB * 8;
    localparam int WDOG = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          clr_rx_rdy;
    logic [AW-1:0] ram_addr;
    logic          ram_d;
    logic          ram_we;
    logic [AW-1:0] core_addr = '0;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [3:0]    core_digit = 4'h0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    snn_image_sequencer #(
        .N_BYTES     (NB),
        .ADDR_W      (AW),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .core_addr  (core_addr),
        .core_start (core_start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference image and bench-side copy of the input-unit RAM
    logic [7:0] img [NB];
    bit         mem     [1024];
    bit         wr_seen [1024];

    int cyc = 0;
    int n_writes = 0, bad_addr = 0, we_busy = 0, last_wr = -1;
    int n_start = 0, start_cyc = -1, n_tx = 0, tx_cyc = -1;

    always @(posedge clk) cyc++;

    // Capture RAM writes and strobe timing mid-cycle
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (int'(ram_addr) < NPIX) begin
                mem[ram_addr]     = ram_d;
                wr_seen[ram_addr] = 1'b1;
            end else begin
                bad_addr++;
            end
            n_writes++;
            last_wr = int'(ram_addr);
            if (busy === 1'b1) we_busy++;
        end
        if (core_start === 1'b1) begin n_start++; start_cyc = cyc; end
        if (tx_start === 1'b1)   begin n_tx++;    tx_cyc = cyc;    end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame_stats();
        for (int a = 0; a < 1024; a++) wr_seen[a] = 1'b0;
        n_writes = 0; bad_addr = 0; we_busy = 0; last_wr = -1;
    endtask

    // Stream n_send image bytes; each acceptance must happen at the later of
    // "rx_rdy raised" and "9 cycles after the previous acceptance".
    task automatic load_image(input int n_send, output int c_last);
        int  raise_cyc, exp_acc, acc, w, gap, prev;
        bit  got;
        prev   = -100;
        c_last = 0;
        for (int k = 0; k < n_send; k++) begin
            rx_data   = img[k];
            rx_rdy    = 1'b1;
            raise_cyc = cyc;
            exp_acc   = (prev + 9 > raise_cyc) ? prev + 9 : raise_cyc;
            got = 1'b0;
            w   = 0;
            while (!got && w < 40) begin
                @(negedge clk);
                if (clr_rx_rdy === 1'b1) got = 1'b1;
                w++;
            end
            acc = cyc;
            if (!got) begin
                chk("clr_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                rx_rdy = 1'b0;
                return;
            end
            chk("accept_cycle", acc, exp_acc);
            prev   = acc;
            c_last = acc;
            @(posedge clk); #1;
            rx_rdy = 1'b0;
            if (k < n_send - 1) begin
                gap = $urandom_range(0, 10);
                repeat (gap) tick();
            end
        end
    endtask

    task automatic check_image();
        int mism, unseen;
        mism = 0; unseen = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (!wr_seen[a]) unseen++;
            else if (mem[a] != img[a / 8][a % 8]) mism++;
        end
        chk("image_bits", mism, 0);
        chk("image_cover", unseen, 0);
        chk("n_writes", n_writes, NPIX);
        chk("bad_addr", bad_addr, 0);
        chk("last_wr_addr", last_wr, NPIX - 1);
        chk("we_while_busy", we_busy, 0);
    endtask

    // mode 0: core_done after a random delay; 1: core never done;
    // 2: core_done in the last watchdog cycle
    task automatic run_compute(input int c_last, input int mode, input logic [3:0] dig);
        int         sc, s0, t0, d, tx_exp;
        logic [7:0] data_exp;
        sc = c_last + 9;
        s0 = n_start;
        t0 = n_tx;
        while (cyc < sc + 1) tick();
        chk("start_cycle", start_cyc, sc);
        chk("start_count", n_start - s0, 1);
        d        = (mode == 0) ? $urandom_range(3, 40) : WDOG;
        tx_exp   = sc + d + 1;
        data_exp = (mode == 1) ? 8'hFF : {4'h0, dig};
        for (int k = 1; k < d; k++) begin
            core_addr = (k == 1) ? 10'h155 : AW'($urandom_range(0, 1023));
            tx_done   = (k == 2);
            @(negedge clk);
            chk("compute_mux", {busy, ram_we, ram_addr}, {1'b1, 1'b0, core_addr});
            @(posedge clk); #1;
        end
        tx_done    = 1'b0;
        core_done  = (mode != 1);
        core_digit = dig;
        tick();
        core_done = 1'b0;
        repeat (2) tick();
        chk("tx_cycle", tx_cyc, tx_exp);
        chk("tx_count", n_tx - t0, 1);
        chk("tx_data", tx_data, data_exp);
        core_done  = 1'b1;
        core_digit = ~dig;
        tick();
        core_done = 1'b0;
        tick();
        chk("tx_hold", tx_data, data_exp);
        chk("tx_no_restart", n_tx - t0, 1);
        chk("busy_tx_wait", busy, 1'b1);
        repeat ($urandom_range(0, 5)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("rearm", {busy, ram_we, ram_addr}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic random_image();
        for (int k = 0; k < NB; k++) img[k] = 8'($urandom);
    endtask

    task automatic full_frame(input int mode, input logic [3:0] dig);
        int c_last;
        clear_frame_stats();
        load_image(NB, c_last);
        run_compute(c_last, mode, dig);
        check_image();
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int         c_last, t0, n_part;
        logic [7:0] low_bits;

        // Reset: everything idle
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs",
            {clr_rx_rdy, ram_we, ram_d, core_start, tx_start, busy, ram_addr, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Spurious core_done while loading is ignored
        t0 = n_tx;
        core_done  = 1'b1;
        core_digit = 4'h3;
        tick();
        core_done = 1'b0;
        tick();
        chk("idle_done_busy", busy, 1'b0);
        chk("idle_done_tx", n_tx - t0, 0);

        // All-0xA5 frame, digit 7
        for (int k = 0; k < NB; k++) img[k] = 8'hA5;
        clear_frame_stats();
        load_image(NB, c_last);
        run_compute(c_last, 0, 4'h7);
        check_image();
        for (int i = 0; i < 8; i++) low_bits[i] = mem[i];
        chk("a5_first_byte", low_bits, 8'hA5);

        // Random frames with random digits
        for (int f = 0; f < 3; f++) begin
            random_image();
            full_frame(0, 4'($urandom_range(0, 9)));
        end

        // Reset in the middle of UNPACK discards the partial image
        random_image();
        n_part = $urandom_range(1, NB - 1);
        load_image(n_part, c_last);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {clr_rx_rdy, ram_we, core_start, tx_start, busy, ram_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        random_image();
        full_frame(0, 4'($urandom_range(0, 9)));

`ifdef SNN_WDOG_EN
        // Core never finishes: error code after WDOG cycles, then normal frames
        random_image();
        full_frame(1, 4'h5);
        random_image();
        full_frame(2, 4'h9);
        random_image();
        full_frame(0, 4'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
